jk_bank_seq_ctrl: RTL and testbench

Command-driven sequencer for a bank of N JK flip-flops. It accepts one command at a time over a valid/ready handshake and drives the per-bit J/K inputs of the bank. Supported commands are clear, parallel load, synchronous up-count and masked toggle, each run for a programmed number of clock cycles. The bank output Q is fed back so the block can generate counter J/K terms. Sits between a host/test controller and the flip-flop bank.

---
 rtl/jk_ctrl_pkg.sv | 18 +
 rtl/jk_count_terms.sv | 16 +
 rtl/jk_bank_seq_ctrl.sv | 83 ++++++++
 tb/tb_jk_bank_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK bank sequencer: command opcodes and FSM states.
package jk_ctrl_pkg;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_COUNT  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_DRIVE = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  // CLEAR and LOAD always run exactly one bank edge, whatever cmd_len says.
  function automatic logic op_is_single(input logic [1:0] op);
    return (op == OP_CLEAR) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/jk_count_terms.sv
// Carry-chain J/K terms for a synchronous up-counter built from JK flip-flops.
module jk_count_terms #(
  parameter int N = 4
) (
  input  logic [N-1:0] q,
  output logic [N-1:0] t
);

  // Bit i toggles only when every lower bit is already 1.
  assign t[0] = 1'b1;

  for (genvar i = 1; i < N; i++) begin : g_term
    assign t[i] = &q[i-1:0];
  end

endmodule

// File: rtl/jk_bank_seq_ctrl.sv
// Command sequencer for a bank of JK flip-flops: accepts one command at a time
// and drives the bank's J/K inputs for the programmed number of edges.
module jk_bank_seq_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          CK,
  input  logic          CLR,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [N-1:0]  cmd_data,
  input  logic [CW-1:0] cmd_len,
  input  logic [N-1:0]  Q,
  output logic [N-1:0]  J,
  output logic [N-1:0]  K,
  output logic          busy,
  output logic          done
);

  logic [1:0]    state;
  logic [1:0]    op_r;
  logic [N-1:0]  data_r;
  logic [CW-1:0] cnt;
  logic [CW-1:0] eff_len;
  logic [N-1:0]  count_t;

  assign eff_len = op_is_single(cmd_op) ? CW'(1) : cmd_len;

  jk_count_terms #(.N(N)) u_count_terms (
    .q (Q),
    .t (count_t)
  );

  // The counter holds the number of bank edges still to drive, so DRIVE exits after the edge where it reads 1.
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      state  <= S_IDLE;
      op_r   <= '0;
      data_r <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r   <= cmd_op;
            data_r <= cmd_data;
            cnt    <= eff_len;
            state  <= (eff_len == '0) ? S_DONE : S_DRIVE;
          end
        end
        S_DRIVE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_DRIVE) || (state == S_DONE);
  assign done      = (state == S_DONE);

  // Outside DRIVE the bank sees J=K=0, i.e. hold.
  always_comb begin
    J = '0;
    K = '0;
    if (state == S_DRIVE) begin
      case (op_r)
        OP_CLEAR:  begin J = '0;      K = '1;       end
        OP_LOAD:   begin J = data_r;  K = ~data_r;  end
        OP_COUNT:  begin J = count_t; K = count_t;  end
        OP_TOGGLE: begin J = data_r;  K = data_r;   end
        default:   begin J = '0;      K = '0;       end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_seq_ctrl.sv
// Bench for jk_bank_seq_ctrl driving a 4-bit behavioural JK bank (preset inactive).
module tb_jk_bank_seq_ctrl;

  localparam logic [1:0] C_CLEAR  = 2'b00;
  localparam logic [1:0] C_LOAD   = 2'b01;
  localparam logic [1:0] C_COUNT  = 2'b10;
  localparam logic [1:0] C_TOGGLE = 2'b11;

  logic       CK = 1'b0;
  logic       CLR = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_data = '0;
  logic [7:0] cmd_len = '0;
  logic [3:0] bank_q = 4'b0000;
  logic [3:0] J, K;
  logic       busy, done;

  int checks = 0;
  int errors = 0;
  logic [3:0] model_q = 4'b0000;

  always #5 CK = ~CK;

  jk_bank_seq_ctrl #(.N(4), .CW(8)) dut (
    .CK        (CK),
    .CLR       (CLR),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .Q         (bank_q),
    .J         (J),
    .K         (K),
    .busy      (busy),
    .done      (done)
  );

  // Behavioural JK flip-flop bank with no clear of its own.
  always @(posedge CK) begin
    for (int i = 0; i < 4; i++) begin
      case ({J[i], K[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end

  // Runs one command to completion from a falling edge, checking every cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
    int eff;
    logic [3:0] exp_j, exp_k;
    eff = (op == C_CLEAR || op == C_LOAD) ? 1 : int'(len);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_len = len;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL ready_before_accept: got %b expected 1", cmd_ready);
    end
    @(posedge CK); @(negedge CK);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_data = 4'($urandom); cmd_len = 8'($urandom);
    for (int e = 0; e < eff; e++) begin
      case (op)
        C_CLEAR:  begin exp_j = 4'b0000; exp_k = 4'b1111; end
        C_LOAD:   begin exp_j = data;    exp_k = ~data;   end
        C_COUNT:  begin exp_j = model_q ^ (model_q + 4'd1); exp_k = exp_j; end
        default:  begin exp_j = data;    exp_k = data;    end
      endcase
      checks++;
      if ({busy, done, cmd_ready} !== 3'b100) begin
        errors++; $display("[TB] FAIL drive_flags: got busy/done/ready=%b expected 100", {busy, done, cmd_ready});
      end
      checks++;
      if ({J, K} !== {exp_j, exp_k}) begin
        errors++; $display("[TB] FAIL drive_jk op=%0d: got J=%b K=%b expected J=%b K=%b", op, J, K, exp_j, exp_k);
      end
      checks++;
      if (bank_q !== model_q) begin
        errors++; $display("[TB] FAIL drive_q: got %b expected %b", bank_q, model_q);
      end
      @(posedge CK); @(negedge CK);
      case (op)
        C_CLEAR:  model_q = 4'b0000;
        C_LOAD:   model_q = data;
        C_COUNT:  model_q = model_q + 4'd1;
        default:  model_q = model_q ^ data;
      endcase
    end
    checks++;
    if ({busy, done, cmd_ready, J, K} !== {3'b110, 8'h00}) begin
      errors++; $display("[TB] FAIL done_cycle: got busy/done/ready=%b J=%b K=%b expected 110 J=0000 K=0000", {busy, done, cmd_ready}, J, K);
    end
    checks++;
    if (bank_q !== model_q) begin
      errors++; $display("[TB] FAIL done_q: got %b expected %b", bank_q, model_q);
    end
    @(posedge CK); @(negedge CK);
    checks++;
    if ({busy, done, cmd_ready, J, K} !== {3'b001, 8'h00}) begin
      errors++; $display("[TB] FAIL idle_after: got busy/done/ready=%b J=%b K=%b expected 001 J=0000 K=0000", {busy, done, cmd_ready}, J, K);
    end
    checks++;
    if (bank_q !== model_q) begin
      errors++; $display("[TB] FAIL idle_q: got %b expected %b", bank_q, model_q);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, cmd_ready, J, K} !== {3'b001, 8'h00}) begin
      errors++; $display("[TB] FAIL reset_outputs: got busy/done/ready=%b J=%b K=%b expected 001 0000 0000", {busy, done, cmd_ready}, J, K);
    end
    #18 CLR = 1'b1;
    @(negedge CK);
  endtask

  task automatic test_load_and_count();
    run_cmd(C_LOAD, 4'b1010, 8'd0);
    checks++;
    if (bank_q !== 4'b1010) begin
      errors++; $display("[TB] FAIL load_1010: got %b expected 1010", bank_q);
    end
    run_cmd(C_COUNT, 4'b0000, 8'd3);
    checks++;
    if (bank_q !== 4'b1101) begin
      errors++; $display("[TB] FAIL count_to_1101: got %b expected 1101", bank_q);
    end
  endtask

  task automatic test_count_wrap();
    run_cmd(C_LOAD, 4'b1110, 8'd7);
    run_cmd(C_COUNT, 4'b1001, 8'd3);
    checks++;
    if (bank_q !== 4'b0001) begin
      errors++; $display("[TB] FAIL count_wrap: got %b expected 0001", bank_q);
    end
  endtask

  task automatic test_toggle();
    run_cmd(C_LOAD, 4'b0101, 8'd0);
    run_cmd(C_TOGGLE, 4'b0011, 8'd2);
    checks++;
    if (bank_q !== 4'b0101) begin
      errors++; $display("[TB] FAIL toggle_twice: got %b expected 0101", bank_q);
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] q_before;
    q_before = bank_q;
    cmd_valid = 1'b1; cmd_op = C_TOGGLE; cmd_data = 4'b1111; cmd_len = 8'd0;
    @(posedge CK); @(negedge CK);
    checks++;
    if ({busy, done, cmd_ready, J, K} !== {3'b110, 8'h00}) begin
      errors++; $display("[TB] FAIL zero_len_done: got busy/done/ready=%b J=%b K=%b expected 110 0000 0000", {busy, done, cmd_ready}, J, K);
    end
    cmd_op = C_LOAD; cmd_data = ~q_before;
    @(posedge CK); @(negedge CK);
    cmd_valid = 1'b0;
    checks++;
    if ({busy, done, cmd_ready, J, K} !== {3'b001, 8'h00}) begin
      errors++; $display("[TB] FAIL valid_in_done_ignored: got busy/done/ready=%b J=%b K=%b expected 001 0000 0000", {busy, done, cmd_ready}, J, K);
    end
    checks++;
    if (bank_q !== q_before) begin
      errors++; $display("[TB] FAIL zero_len_q: got %b expected %b", bank_q, q_before);
    end
  endtask

  task automatic test_abort();
    run_cmd(C_CLEAR, 4'b1111, 8'd9);
    cmd_valid = 1'b1; cmd_op = C_COUNT; cmd_len = 8'd10;
    @(posedge CK); @(negedge CK);
    cmd_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge CK); @(negedge CK);
      model_q = model_q + 4'd1;
    end
    CLR = 1'b0;
    #1;
    checks++;
    if ({busy, done, cmd_ready, J, K} !== {3'b001, 8'h00}) begin
      errors++; $display("[TB] FAIL abort_outputs: got busy/done/ready=%b J=%b K=%b expected 001 0000 0000", {busy, done, cmd_ready}, J, K);
    end
    repeat (2) @(negedge CK);
    CLR = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_ready: got %b expected 1", cmd_ready);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge CK);
      checks++;
      if ({done, bank_q} !== {1'b0, 4'b0011}) begin
        errors++; $display("[TB] FAIL abort_hold c=%0d: got done=%b Q=%b expected done=0 Q=0011", c, done, bank_q);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom), 4'($urandom), 8'($urandom_range(0, 12)));
    end
  endtask

  initial begin
    test_reset();
    test_load_and_count();
    test_count_wrap();
    test_toggle();
    test_zero_len();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
